// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the zero register and the
// forwarding-source encoding used by the operand stage.
package cpu_pkg;
   localparam int XLEN   = 32;
   localparam int CTRL_W = 16;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_EX  = 2'd3
   } fwd_sel_e;
endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand bypass resolver: picks the youngest in-flight producer of the
// source register (EX > MEM > WB > register file). x0 always reads as 0.
import cpu_pkg::*;

module operand_fwd_mux #(
   parameter int XLEN = cpu_pkg::XLEN
) (
   input  logic [4:0]      src_index,
   input  logic [XLEN-1:0] rf_data,
   input  logic            ex_fwd_en,
   input  logic [4:0]      ex_rd_index,
   input  logic [XLEN-1:0] ex_result,
   input  logic            mem_rd_we,
   input  logic [4:0]      mem_rd_index,
   input  logic [XLEN-1:0] mem_result,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd_index,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] op,
   output fwd_sel_e        sel
);

   // Priority select of the operand source.
   always_comb begin
      sel = FWD_RF;
      op  = rf_data;
      if (src_index == REG_ZERO) begin
         op = '0;
      end else if (ex_fwd_en && ex_rd_index == src_index) begin
         sel = FWD_EX;
         op  = ex_result;
      end else if (mem_rd_we && mem_rd_index == src_index) begin
         sel = FWD_MEM;
         op  = mem_result;
      end else if (wb_en && wb_rd_index == src_index) begin
         sel = FWD_WB;
         op  = wb_data;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves RAW hazards by forwarding, stalls decode on
// load-use, and holds the ID/EX pipeline register feeding the ALU.
// Optional perf counters are built when OPERAND_PERF_EN is defined.
import cpu_pkg::*;

module id_ex_operand_stage #(
   parameter int XLEN   = cpu_pkg::XLEN,
   parameter int CTRL_W = cpu_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [4:0]        id_rs1_index,
   input  logic [4:0]        id_rs2_index,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [4:0]        id_rd_index,
   input  logic              id_rd_we,
   input  logic              id_is_load,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic [XLEN-1:0]   ex_result,
   input  logic [4:0]        mem_rd_index,
   input  logic              mem_rd_we,
   input  logic [XLEN-1:0]   mem_result,
   input  logic              wb_en,
   input  logic [4:0]        W_rd_index,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_pc,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [4:0]        ex_rd_index,
   output logic              ex_rd_we,
   output logic              ex_is_load
`ifdef OPERAND_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_fwd_cnt
`endif
);

   logic [1:0][4:0]      src_idx;
   logic [1:0]           src_used;
   logic [1:0][XLEN-1:0] src_rf;
   logic [1:0][XLEN-1:0] src_op;
   fwd_sel_e             src_sel [2];

   // Tracks a load that has moved into MEM, whose data is not forwardable
   // until it reaches WB.
   logic       mem_ld_vld;
   logic [4:0] mem_ld_rd;

   logic ld_ex, ld_mem, load_use, capture;

   assign src_idx  = {id_rs2_index, id_rs1_index};
   assign src_used = {id_rs2_used, id_rs1_used};
   assign src_rf   = {rs2_data, rs1_data};

   for (genvar g = 0; g < 2; g++) begin : g_fwd
      operand_fwd_mux #(.XLEN(XLEN)) u_fwd (
         .src_index    (src_idx[g]),
         .rf_data      (src_rf[g]),
         .ex_fwd_en    (ex_valid & ex_rd_we),
         .ex_rd_index  (ex_rd_index),
         .ex_result    (ex_result),
         .mem_rd_we    (mem_rd_we),
         .mem_rd_index (mem_rd_index),
         .mem_result   (mem_result),
         .wb_en        (wb_en),
         .wb_rd_index  (W_rd_index),
         .wb_data      (wb_data),
         .op           (src_op[g]),
         .sel          (src_sel[g])
      );
   end

   // Load-use detection: dependent on a load in EX, or on a load now in MEM.
   always_comb begin
      ld_ex = ex_valid && ex_is_load && ex_rd_we && (ex_rd_index != REG_ZERO) &&
              ((id_rs1_used && id_rs1_index == ex_rd_index) ||
               (id_rs2_used && id_rs2_index == ex_rd_index));
      ld_mem = mem_ld_vld && (mem_ld_rd != REG_ZERO) &&
               ((id_rs1_used && id_rs1_index == mem_ld_rd) ||
                (id_rs2_used && id_rs2_index == mem_ld_rd));
      load_use = id_valid && (ld_ex || ld_mem);
   end

   assign id_stall = ~flush & (load_use | ~ex_ready);
   assign capture  = ~flush & ex_ready & ~load_use;

   // ID/EX register: flush > backpressure hold > load-use bubble > capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid    <= 1'b0;
         ex_op1      <= '0;
         ex_op2      <= '0;
         ex_imm      <= '0;
         ex_pc       <= '0;
         ex_ctrl     <= '0;
         ex_rd_index <= '0;
         ex_rd_we    <= 1'b0;
         ex_is_load  <= 1'b0;
      end else if (flush || (ex_ready && load_use)) begin
         ex_valid   <= 1'b0;
         ex_rd_we   <= 1'b0;
         ex_is_load <= 1'b0;
      end else if (ex_ready) begin
         ex_valid    <= id_valid;
         ex_op1      <= src_op[0];
         ex_op2      <= src_op[1];
         ex_imm      <= id_imm;
         ex_pc       <= id_pc;
         ex_ctrl     <= id_ctrl;
         ex_rd_index <= id_rd_index;
         ex_rd_we    <= id_valid & id_rd_we;
         ex_is_load  <= id_valid & id_is_load;
      end
   end

   // Follow the EX instruction into MEM whenever the backend advances.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_ld_vld <= 1'b0;
         mem_ld_rd  <= '0;
      end else if (ex_ready) begin
         mem_ld_vld <= ex_valid & ex_is_load & ex_rd_we;
         mem_ld_rd  <= ex_rd_index;
      end
   end

`ifdef OPERAND_PERF_EN
   logic [1:0] fwd_hit;
   assign fwd_hit[0] = id_rs1_used && (src_sel[0] != FWD_RF);
   assign fwd_hit[1] = id_rs2_used && (src_sel[1] != FWD_RF);

   // Stall cycles and forwarded operands of captured valid instructions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else begin
         if (load_use)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (capture && id_valid)
            perf_fwd_cnt <= perf_fwd_cnt + 32'(fwd_hit[0]) + 32'(fwd_hit[1]);
      end
   end
`endif

   a_no_x_valid : assert property (@(posedge clk) disable iff (!rst) !$isunknown(ex_valid));
   a_flush_nostall : assert property (@(posedge clk) disable iff (!rst) flush |-> !id_stall);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a table of single-cycle
// vectors plus hand sequences for load-use, flush, backpressure and reset.
module tb_id_ex_operand_stage;
   localparam int XLEN = 32;
   localparam int CTRL_W = 16;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
   logic [4:0] id_rs1_index, id_rs2_index, id_rd_index, mem_rd_index, W_rd_index;
   logic [CTRL_W-1:0] id_ctrl;
   logic [XLEN-1:0] id_imm, id_pc, rs1_data, rs2_data, ex_result, mem_result, wb_data;
   logic mem_rd_we, wb_en, flush, ex_ready;
   logic id_stall, ex_valid, ex_rd_we, ex_is_load;
   logic [XLEN-1:0] ex_op1, ex_op2, ex_imm, ex_pc;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [4:0] ex_rd_index;
`ifdef OPERAND_PERF_EN
   logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

   id_ex_operand_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_index(id_rd_index), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
      .id_ctrl(id_ctrl), .id_imm(id_imm), .id_pc(id_pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
      .mem_rd_index(mem_rd_index), .mem_rd_we(mem_rd_we), .mem_result(mem_result),
      .wb_en(wb_en), .W_rd_index(W_rd_index), .wb_data(wb_data),
      .flush(flush), .ex_ready(ex_ready), .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
      .ex_pc(ex_pc), .ex_ctrl(ex_ctrl), .ex_rd_index(ex_rd_index),
      .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load)
`ifdef OPERAND_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic vld, u1, u2, we, ld, mwe, wbe, flush, rdy;
      logic [4:0] rs1, rs2, rd, mrd, wrd;
      logic [31:0] r1d, r2d, exr, mres, wbd;
      logic stall;
      logic [31:0] e1, e2;
   } vec_t;

   typedef struct {
      logic [31:0] op1, op2, pc;
      logic we;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   vec_t tbl[9];
   vec_t t;
   int total = 0;
   int passed = 0;
   int seq = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   function automatic vec_t idle();
      vec_t v;
      v = '{default: '0};
      v.rdy = 1'b1;
      return v;
   endfunction

   // Drive one cycle of stimulus, check the stall mid-cycle and the
   // registered outputs just after the edge.
   task automatic apply(input vec_t v, input string name);
      exp_t e;
      logic hold;
      id_valid = v.vld; id_rs1_index = v.rs1; id_rs2_index = v.rs2;
      id_rs1_used = v.u1; id_rs2_used = v.u2; id_rd_index = v.rd;
      id_rd_we = v.we; id_is_load = v.ld; rs1_data = v.r1d; rs2_data = v.r2d;
      ex_result = v.exr; mem_rd_index = v.mrd; mem_rd_we = v.mwe; mem_result = v.mres;
      wb_en = v.wbe; W_rd_index = v.wrd; wb_data = v.wbd;
      flush = v.flush; ex_ready = v.rdy;
      id_pc = 32'h100 + 32'(seq) * 4; id_imm = 32'(seq); id_ctrl = 16'(seq);
      seq++;
      #4;
      chk({name, ".stall"}, {31'd0, id_stall}, {31'd0, v.stall});
      hold = !v.rdy && !v.flush;
      if (v.vld && !v.stall && !v.flush) begin
         e.op1 = v.e1; e.op2 = v.e2; e.pc = id_pc; e.we = v.we;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         last = e;
         chk({name, ".valid"}, {31'd0, ex_valid}, 32'd1);
         chk({name, ".op1"}, ex_op1, e.op1);
         chk({name, ".op2"}, ex_op2, e.op2);
         chk({name, ".pc"}, ex_pc, e.pc);
         chk({name, ".rd_we"}, {31'd0, ex_rd_we}, {31'd0, e.we});
      end else if (hold) begin
         chk({name, ".hold_valid"}, {31'd0, ex_valid}, 32'd1);
         chk({name, ".hold_op1"}, ex_op1, last.op1);
         chk({name, ".hold_op2"}, ex_op2, last.op2);
         chk({name, ".hold_pc"}, ex_pc, last.pc);
      end else begin
         chk({name, ".bubble_valid"}, {31'd0, ex_valid}, 32'd0);
         chk({name, ".bubble_rd_we"}, {31'd0, ex_rd_we}, 32'd0);
      end
   endtask

   initial begin
      // Table: each row's EX-stage state comes from the previous row.
      t = idle(); t.vld=1; t.rs1=1; t.rs2=2; t.u1=1; t.u2=1; t.rd=5; t.we=1;
      t.r1d=32'hA; t.r2d=32'hB; t.e1=32'hA; t.e2=32'hB; tbl[0]=t;
      t = idle(); t.vld=1; t.rs1=5; t.rs2=6; t.u1=1; t.u2=1; t.rd=9; t.we=1;
      t.r1d=32'h99; t.r2d=32'h66; t.exr=32'h11; t.e1=32'h11; t.e2=32'h66; tbl[1]=t;
      t = idle(); t.vld=1; t.rs1=8; t.rs2=7; t.u1=1; t.u2=1; t.rd=10;
      t.r1d=32'h88; t.r2d=32'h0; t.exr=32'h55; t.wbe=1; t.wrd=7; t.wbd=32'hDEAD;
      t.e1=32'h88; t.e2=32'hDEAD; tbl[2]=t;
      t = idle(); t.vld=1; t.rs1=4; t.rs2=0; t.u1=1; t.u2=1; t.rd=0; t.we=1;
      t.r1d=32'h1; t.r2d=32'h77; t.mrd=4; t.mwe=1; t.mres=32'h4444;
      t.wbe=1; t.wrd=4; t.wbd=32'h5555; t.e1=32'h4444; t.e2=32'h0; tbl[3]=t;
      t = idle(); t.vld=1; t.rs1=0; t.rs2=3; t.u1=1; t.u2=1; t.rd=0; t.we=1; t.ld=1;
      t.r1d=32'hAB; t.r2d=32'h33; t.exr=32'hFF; t.e1=32'h0; t.e2=32'h33; tbl[4]=t;
      t = idle(); t.vld=1; t.rs1=0; t.rs2=0; t.u1=1; t.u2=1; t.rd=12; t.we=1;
      t.r1d=32'hCD; t.r2d=32'hEF; t.exr=32'hFF; t.e1=32'h0; t.e2=32'h0; tbl[5]=t;
      t = idle(); t.vld=1; t.rs1=12; t.rs2=13; t.u1=1; t.u2=1;
      t.r1d=32'h1; t.r2d=32'h2; t.exr=32'hE1; t.mrd=12; t.mwe=1; t.mres=32'hA1;
      t.wbe=1; t.wrd=13; t.wbd=32'h13; t.e1=32'hE1; t.e2=32'h13; tbl[6]=t;
      t = idle(); t.vld=0; t.rd=12; t.we=1; tbl[7]=t;
      t = idle(); t.vld=1; t.rs1=12; t.u1=1; t.r1d=32'h12; t.exr=32'hE1;
      t.e1=32'h12; t.e2=32'h0; tbl[8]=t;

      rst = 1'b0;
      t = idle();
      id_valid=0; id_rs1_index=0; id_rs2_index=0; id_rs1_used=0; id_rs2_used=0;
      id_rd_index=0; id_rd_we=0; id_is_load=0; id_ctrl=0; id_imm=0; id_pc=0;
      rs1_data=0; rs2_data=0; ex_result=0; mem_rd_index=0; mem_rd_we=0;
      mem_result=0; wb_en=0; W_rd_index=0; wb_data=0; flush=0; ex_ready=1;
      #12;
      chk("reset.valid", {31'd0, ex_valid}, 32'd0);
      chk("reset.op1", ex_op1, 32'd0);
      chk("reset.pc", ex_pc, 32'd0);
      chk("reset.stall", {31'd0, id_stall}, 32'd0);
`ifdef OPERAND_PERF_EN
      chk("reset.perf_stall", perf_stall_cnt, 32'd0);
      chk("reset.perf_fwd", perf_fwd_cnt, 32'd0);
`endif
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Load-use on x3: two stall cycles, then operand from WB.
      t = idle(); t.vld=1; t.rd=3; t.we=1; t.ld=1; t.e1=0; t.e2=0;
      apply(t, "lu_load");
      t = idle(); t.vld=1; t.rs1=3; t.u1=1; t.r1d=32'hBAD; t.stall=1;
      apply(t, "lu_stall1");
      t.mrd=3; t.mwe=1; t.mres=32'hBAD0;
      apply(t, "lu_stall2");
      t.mwe=0; t.wbe=1; t.wrd=3; t.wbd=32'h1234; t.stall=0; t.e1=32'h1234;
      apply(t, "lu_wb");

      // Flush while a load-use hazard is present.
      t = idle(); t.vld=1; t.rd=3; t.we=1; t.ld=1; t.e1=0; t.e2=0;
      apply(t, "fl_load");
      t = idle(); t.vld=1; t.rs1=3; t.u1=1; t.flush=1; t.stall=0;
      apply(t, "fl_flush");
      t = idle(); apply(t, "fl_idle0");
      t = idle(); apply(t, "fl_idle1");

      // Backpressure hold for 3 cycles, then asynchronous reset mid-hold.
      t = idle(); t.vld=1; t.rs1=1; t.rs2=2; t.u1=1; t.u2=1; t.rd=14; t.we=1;
      t.r1d=32'hC1; t.r2d=32'hC2; t.e1=32'hC1; t.e2=32'hC2;
      apply(t, "bp_cap");
      for (int k = 0; k < 3; k++) begin
         t = idle(); t.vld=1; t.rs1=6; t.u1=1; t.r1d=32'h600 + 32'(k);
         t.rdy=0; t.stall=1;
         apply(t, $sformatf("bp_hold%0d", k));
      end
      #2 rst = 1'b0;
      #1;
      chk("async_rst.valid", {31'd0, ex_valid}, 32'd0);
      chk("async_rst.op1", ex_op1, 32'd0);
      chk("async_rst.rd_we", {31'd0, ex_rd_we}, 32'd0);
      ex_ready = 1'b1; id_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      #1;
      chk("post_rst.stall", {31'd0, id_stall}, 32'd0);
`ifdef OPERAND_PERF_EN
      chk("post_rst.perf_stall", perf_stall_cnt, 32'd0);
      chk("post_rst.perf_fwd", perf_fwd_cnt, 32'd0);
`endif
      @(posedge clk); #1;
      chk("post_rst.valid", {31'd0, ex_valid}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
